// File: rtl/conv2d_pkg.sv
// Shared parameters, types and sizing helpers for the stride-2 conv window sequencer.
package conv2d_pkg;

    localparam int unsigned FILT_DIM_DEF  = 3;
    localparam int unsigned IN_WIDTH_DEF  = 9;
    localparam int unsigned IN_HEIGHT_DEF = 9;
    localparam int unsigned bitWidth      = 8;

    typedef logic signed [bitWidth-1:0] pix_t;

    typedef enum logic {
        STREAM = 1'b0,
        STALL  = 1'b1
    } ctrl_state_t;

    function automatic int unsigned out_dim(input int unsigned side, input int unsigned filt);
        return (side - filt) / 2 + 1;
    endfunction

    // Keeps index ports at least one bit wide when only one output position exists.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned OUT_DIM_DEF = out_dim(IN_WIDTH_DEF, FILT_DIM_DEF);
    localparam int unsigned IDX_W_DEF   = idx_width(OUT_DIM_DEF);

endpackage

// File: rtl/conv2d_pos_counter.sv
// Raster row/column tracker with parity of the offset from the first full window.
module conv2d_pos_counter
    import conv2d_pkg::*;
#(
    parameter  int unsigned filtDimension = FILT_DIM_DEF,
    parameter  int unsigned inputWidth    = IN_WIDTH_DEF,
    parameter  int unsigned inputHeight   = IN_HEIGHT_DEF,
    localparam int unsigned colWidth      = idx_width(inputWidth),
    localparam int unsigned rowWidth      = idx_width(inputHeight)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    output logic [colWidth-1:0] col,
    output logic [rowWidth-1:0] row,
    output logic                col_odd,
    output logic                row_odd,
    output logic                col_in,
    output logic                row_in,
    output logic                last_pixel
);

    // Parity of (0 - (K-1)), reloaded whenever a counter returns to zero.
    localparam logic ODD_AT_ZERO = 1'((filtDimension - 1) % 2);

    logic col_last;
    logic row_last;

    assign col_last   = (col == colWidth'(inputWidth - 1));
    assign row_last   = (row == rowWidth'(inputHeight - 1));
    assign last_pixel = col_last && row_last;
    assign col_in     = (col >= colWidth'(filtDimension - 1));
    assign row_in     = (row >= rowWidth'(filtDimension - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col     <= '0;
            row     <= '0;
            col_odd <= ODD_AT_ZERO;
            row_odd <= ODD_AT_ZERO;
        end else if (enable) begin
            if (col_last) begin
                col     <= '0;
                col_odd <= ODD_AT_ZERO;
                if (row_last) begin
                    row     <= '0;
                    row_odd <= ODD_AT_ZERO;
                end else begin
                    row     <= row + rowWidth'(1);
                    row_odd <= ~row_odd;
                end
            end else begin
                col     <= col + colWidth'(1);
                col_odd <= ~col_odd;
            end
        end
    end

endmodule

// File: rtl/conv2d_stride2_window_ctrl.sv
// Stride-2 window sequencer: pixel handshake, line-buffer hold control and window flagging.
module conv2d_stride2_window_ctrl
    import conv2d_pkg::*;
#(
    parameter  int unsigned filtDimension = FILT_DIM_DEF,
    parameter  int unsigned inputWidth    = IN_WIDTH_DEF,
    parameter  int unsigned inputHeight   = IN_HEIGHT_DEF,
    localparam int unsigned outDim        = out_dim(inputWidth, filtDimension),
    localparam int unsigned outDimH       = out_dim(inputHeight, filtDimension),
    localparam int unsigned idxWidth      = idx_width((outDim > outDimH) ? outDim : outDimH)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                delay,
    output logic                win_valid,
    input  logic                win_ready,
    output logic [idxWidth-1:0] win_row,
    output logic [idxWidth-1:0] win_col,
    output logic                frame_done
);

    localparam int unsigned colWidth = idx_width(inputWidth);
    localparam int unsigned rowWidth = idx_width(inputHeight);

    logic [colWidth-1:0] col;
    logic [rowWidth-1:0] row;
    logic [colWidth-1:0] col_off;
    logic [rowWidth-1:0] row_off;
    logic                col_odd;
    logic                row_odd;
    logic                col_in;
    logic                row_in;
    logic                last_pixel;
    logic                acc;
    logic                q;
    ctrl_state_t         state;

    conv2d_pos_counter #(
        .filtDimension(filtDimension),
        .inputWidth   (inputWidth),
        .inputHeight  (inputHeight)
    ) u_pos (
        .clock     (clock),
        .reset     (reset),
        .enable    (acc),
        .col       (col),
        .row       (row),
        .col_odd   (col_odd),
        .row_odd   (row_odd),
        .col_in    (col_in),
        .row_in    (row_in),
        .last_pixel(last_pixel)
    );

    // STALL is not stored: an unconsumed window freezes the whole chain.
    assign state    = (win_valid && !win_ready) ? STALL : STREAM;
    assign in_ready = !reset && (state == STREAM);
    assign acc      = in_valid && in_ready;
    assign delay    = !acc;
    assign q        = acc && row_in && col_in && !row_odd && !col_odd;
    assign col_off  = col - colWidth'(filtDimension - 1);
    assign row_off  = row - rowWidth'(filtDimension - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_valid  <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= acc && last_pixel;
            if (q) begin
                win_valid <= 1'b1;
                win_row   <= idxWidth'(row_off >> 1);
                win_col   <= idxWidth'(col_off >> 1);
            end else if (win_valid && win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

endmodule
